// File: rtl/short_preamble_seq.sv
// Short training field sequencer: walks the 16-entry preamble ROM
// NUM_REPS times and streams registered I/Q samples on valid/ready.
`timescale 1ns/1ps
module short_preamble_seq #(
  parameter int NUM_REPS = 10,
  parameter int DW       = 16,
  parameter int WINDOW   = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic [3:0]    rom_addr,
  input  logic [DW-1:0] rom_i,
  input  logic [DW-1:0] rom_q,
  output logic [DW-1:0] out_i,
  output logic [DW-1:0] out_q,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [3:0] REP_LAST = 4'(NUM_REPS - 1);

  state_t        state, state_n;
  logic [3:0]    rep, rep_n;
  logic [3:0]    addr_n;
  logic [DW-1:0] i_n, q_n;
  logic          valid_n, last_n;
  logic          load, fin, accept, first;

  assign load   = (state == RUN) &&
                  (!out_valid || out_ready);
  assign fin    = (rom_addr == 4'd15) &&
                  (rep == REP_LAST);
  assign accept = out_valid && out_ready;
  assign first  = (WINDOW != 0) && (rep == 4'd0) &&
                  (rom_addr == 4'd0);

  assign busy = (state != IDLE);
  assign done = (state == DRAIN) && accept && !abort;

  always_comb begin
    state_n = state;
    rep_n   = rep;
    addr_n  = rom_addr;
    i_n     = out_i;
    q_n     = out_q;
    valid_n = out_valid;
    last_n  = out_last;
    if (abort) begin
      state_n = IDLE;
      rep_n   = 4'd0;
      addr_n  = 4'd0;
      valid_n = 1'b0;
      last_n  = 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        state_n = RUN;
        rep_n   = 4'd0;
        addr_n  = 4'd0;
      end
    end else if (load) begin
      // Burst window edge: only the very first sample is halved
      if (first) begin
        i_n = {rom_i[DW-1], rom_i[DW-1:1]};
        q_n = {rom_q[DW-1], rom_q[DW-1:1]};
      end else begin
        i_n = rom_i;
        q_n = rom_q;
      end
      valid_n = 1'b1;
      addr_n  = rom_addr + 4'd1;
      if (rom_addr == 4'd15)
        rep_n = rep + 4'd1;
      if (fin) begin
        last_n  = 1'b1;
        state_n = DRAIN;
      end
    end else if (state == DRAIN && accept) begin
      valid_n = 1'b0;
      last_n  = 1'b0;
      state_n = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rep       <= 4'd0;
      rom_addr  <= 4'd0;
      out_i     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      rep       <= rep_n;
      rom_addr  <= addr_n;
      out_i     <= i_n;
      out_q     <= q_n;
      out_valid <= valid_n;
      out_last  <= last_n;
    end
  end

endmodule

// File: tb/tb_short_preamble_seq.sv
// Directed bench for short_preamble_seq: full bursts, window,
// stalls, abort, ignored starts, reset and a single-period build.
`timescale 1ns/1ps
module tb_short_preamble_seq;

  logic        clock = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [3:0]  rom_addr;
  logic [15:0] rom_i, rom_q, out_i, out_q;
  logic        out_valid, out_last, busy, done;

  logic        start1, out_ready1;
  logic [3:0]  rom_addr1;
  logic [15:0] rom_i1, rom_q1, out_i1, out_q1;
  logic        out_valid1, out_last1, busy1, done1;

  int checks = 0;
  int errors = 0;

  logic [15:0] ti [16] = '{
    16'h05E3, 16'hEF0C, 16'hFE51, 16'h1247,
    16'h0BC2, 16'h1239, 16'hFF1A, 16'hEE3D,
    16'h0A11, 16'h0333, 16'hF2C8, 16'hE08A,
    16'h0BC5, 16'h1C84, 16'hF7A0, 16'h004D};
  logic [15:0] tq [16] = '{
    16'h05E3, 16'h004D, 16'hEE81, 16'hFE9B,
    16'h0012, 16'hFE8E, 16'hEE90, 16'h0051,
    16'h0A77, 16'h0055, 16'hEE5C, 16'hFE6D,
    16'h0BA0, 16'hFE12, 16'hEF7F, 16'hEF0C};

  always #5 clock = ~clock;

  assign rom_i  = ti[rom_addr];
  assign rom_q  = tq[rom_addr];
  assign rom_i1 = ti[rom_addr1];
  assign rom_q1 = tq[rom_addr1];

  short_preamble_seq dut (
    .clock(clock), .reset(reset),
    .start(start), .abort(abort),
    .rom_addr(rom_addr),
    .rom_i(rom_i), .rom_q(rom_q),
    .out_i(out_i), .out_q(out_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy), .done(done));

  short_preamble_seq #(.NUM_REPS(1)) dut1 (
    .clock(clock), .reset(reset),
    .start(start1), .abort(1'b0),
    .rom_addr(rom_addr1),
    .rom_i(rom_i1), .rom_q(rom_q1),
    .out_i(out_i1), .out_q(out_q1),
    .out_valid(out_valid1),
    .out_ready(out_ready1),
    .out_last(out_last1),
    .busy(busy1), .done(done1));

  function automatic logic [15:0] exp_i(int k);
    logic [15:0] s;
    s = ti[k % 16];
    if (k == 0) s = {s[15], s[15:1]};
    return s;
  endfunction

  function automatic logic [15:0] exp_q(int k);
    logic [15:0] s;
    s = tq[k % 16];
    if (k == 0) s = {s[15], s[15:1]};
    return s;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    out_ready = 1'b0; start1 = 1'b0;
    out_ready1 = 1'b0;
    tick(); tick();
    checks++;
    if ({rom_addr, out_i, out_q, out_valid,
         out_last, busy, done} !== 40'h0) begin
      errors++;
      $display("FAIL reset got %h/%h/%h v%b l%b b%b d%b exp 0",
        rom_addr, out_i, out_q, out_valid,
        out_last, busy, done);
    end
    checks++;
    if ({rom_addr1, out_i1, out_q1, out_valid1,
         out_last1, busy1, done1} !== 40'h0) begin
      errors++;
      $display("FAIL reset1 got v%b b%b exp 0",
        out_valid1, busy1);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, out_valid, rom_addr} !== 6'b10_0000) begin
      errors++;
      $display("FAIL start_ack got b%b v%b a%h exp b1 v0 a0",
        busy, out_valid, rom_addr);
    end
    tick();
    for (int k = 0; k < 160; k++) begin
      checks++;
      if ({out_valid, out_i, out_q, out_last, done} !==
          {1'b1, exp_i(k), exp_q(k),
           1'(k == 159), 1'(k == 159)}) begin
        errors++;
        $display("FAIL stream #%0d got v%b %h/%h l%b d%b exp %h/%h",
          k, out_valid, out_i, out_q, out_last, done,
          exp_i(k), exp_q(k));
      end
      tick();
    end
    checks++;
    if ({out_valid, busy, done, out_last} !== 4'b0) begin
      errors++;
      $display("FAIL stream_end got v%b b%b d%b l%b exp 0",
        out_valid, busy, done, out_last);
    end
  endtask

  task automatic test_window();
    logic [31:0] s0, s1, s16, s159;
    logic        l159;
    s0 = '0; s1 = '0; s16 = '0; s159 = '0; l159 = 1'b0;
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 160; k++) begin
      if (k == 0)   s0  = {out_i, out_q};
      if (k == 1)   s1  = {out_i, out_q};
      if (k == 16)  s16 = {out_i, out_q};
      if (k == 159) begin
        s159 = {out_i, out_q};
        l159 = out_last;
      end
      tick();
    end
    checks++;
    if (s0 !== 32'h02F1_02F1) begin
      errors++;
      $display("FAIL win_s0 got %h exp 02f102f1", s0);
    end
    checks++;
    if (s1 !== 32'hEF0C_004D) begin
      errors++;
      $display("FAIL win_s1 got %h exp ef0c004d", s1);
    end
    checks++;
    if (s16 !== 32'h05E3_05E3) begin
      errors++;
      $display("FAIL win_s16 got %h exp 05e305e3", s16);
    end
    checks++;
    if ({s159, l159} !== {32'h004D_EF0C, 1'b1}) begin
      errors++;
      $display("FAIL win_s159 got %h l%b exp 004def0c l1",
        s159, l159);
    end
  endtask

  task automatic test_random_ready();
    int k;
    logic stalled;
    logic [15:0] pi, pq;
    logic [3:0] pa;
    logic pl;
    k = 0; stalled = 1'b0;
    pi = '0; pq = '0; pa = '0; pl = 1'b0;
    start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && k < 160; cyc++) begin
      if (stalled) begin
        checks++;
        if ({out_valid, out_i, out_q, out_last, rom_addr} !==
            {1'b1, pi, pq, pl, pa}) begin
          errors++;
          $display("FAIL stall_hold #%0d got %h/%h l%b a%h exp %h/%h l%b a%h",
            k, out_i, out_q, out_last, rom_addr, pi, pq, pl, pa);
        end
      end
      if (out_valid) begin
        checks++;
        if ({out_i, out_q, out_last} !==
            {exp_i(k), exp_q(k), 1'(k == 159)}) begin
          errors++;
          $display("FAIL rnd #%0d got %h/%h l%b exp %h/%h",
            k, out_i, out_q, out_last, exp_i(k), exp_q(k));
        end
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (done !== 1'(k == 159)) begin
          errors++;
          $display("FAIL rnd_done #%0d got %b exp %b",
            k, done, (k == 159));
        end
        k++;
      end
      stalled = out_valid && !out_ready;
      pi = out_i; pq = out_q; pl = out_last; pa = rom_addr;
      tick();
    end
    checks++;
    if (k != 160) begin
      errors++;
      $display("FAIL rnd_count got %0d exp 160", k);
    end
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rnd_end got v%b b%b exp 0",
        out_valid, busy);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_abort();
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (70) tick();
    out_ready = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_i, out_q} !==
        {1'b1, exp_i(70), exp_q(70)}) begin
      errors++;
      $display("FAIL abort_pre got v%b %h/%h exp %h/%h",
        out_valid, out_i, out_q, exp_i(70), exp_q(70));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({out_valid, busy, out_last, rom_addr, done} !==
        8'h00) begin
      errors++;
      $display("FAIL abort got v%b b%b l%b a%h d%b exp 0",
        out_valid, busy, out_last, rom_addr, done);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({out_valid, busy, done} !== 3'b000) begin
        errors++;
        $display("FAIL abort_idle c%0d got v%b b%b d%b exp 0",
          c, out_valid, busy, done);
      end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 160; k++) begin
      checks++;
      if ({out_valid, out_i, out_q, out_last} !==
          {1'b1, exp_i(k), exp_q(k), 1'(k == 159)}) begin
        errors++;
        $display("FAIL reburst #%0d got v%b %h/%h exp %h/%h",
          k, out_valid, out_i, out_q, exp_i(k), exp_q(k));
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int k = 0; k < 160; k++) begin
      start = (k % 3 == 1) || (k == 159);
      checks++;
      if ({out_valid, out_i, out_q, out_last, done} !==
          {1'b1, exp_i(k), exp_q(k),
           1'(k == 159), 1'(k == 159)}) begin
        errors++;
        $display("FAIL ign #%0d got v%b %h/%h l%b d%b exp %h/%h",
          k, out_valid, out_i, out_q, out_last, done,
          exp_i(k), exp_q(k));
      end
      tick();
    end
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL ign_idle c%0d got v%b b%b exp 0",
          c, out_valid, busy);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    checks++;
    if ({out_valid, busy} !== 2'b11) begin
      errors++;
      $display("FAIL rst_pre got v%b b%b exp 11",
        out_valid, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({rom_addr, out_i, out_q, out_valid,
         out_last, busy, done} !== 40'h0) begin
      errors++;
      $display("FAIL rst_mid got %h/%h/%h v%b l%b b%b d%b exp 0",
        rom_addr, out_i, out_q, out_valid,
        out_last, busy, done);
    end
    tick();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_after got v%b b%b exp 0",
        out_valid, busy);
    end
  endtask

  task automatic test_one_rep();
    out_ready1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({out_valid1, out_i1, out_q1, out_last1, done1} !==
          {1'b1, exp_i(k), exp_q(k),
           1'(k == 15), 1'(k == 15)}) begin
        errors++;
        $display("FAIL rep1 #%0d got v%b %h/%h l%b d%b exp %h/%h",
          k, out_valid1, out_i1, out_q1, out_last1, done1,
          exp_i(k), exp_q(k));
      end
      tick();
    end
    checks++;
    if ({out_valid1, busy1, out_last1} !== 3'b000) begin
      errors++;
      $display("FAIL rep1_end got v%b b%b l%b exp 0",
        out_valid1, busy1, out_last1);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_window();
    test_random_ready();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_one_rep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
